systolic_mm_engine: RTL
=======================

Name: systolic_mm_engine

Overview:
- Parametrised N x N output-stationary systolic matrix-multiply engine computing C = A x B, where A is N x K and B is K x N, with K set per job.
- Contains the input skew registers, the PE grid, the job control FSM and a row-serial result readout with a valid/ready handshake.
- Replaces fixed 4x4 free-running arrays whose done is purely count-based.
- Sits between the operand streaming DMA and the result writeback.

Parameters:
N, 4, array dimension (rows = columns), 2..16
DW, 16, signed operand width
KW, 8, width of k_len; max K = 2^KW-1
AW, 2*DW+KW, signed accumulator/result width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  job start pulse; sampled only in IDLE
k_len  in  KW  inner dimension K; sampled with start
in_valid  in  1  operand beat valid
in_ready  out  1  engine accepts beat; high only in LOAD
a_vec  in  N*DW  column k of A; slice i = A[i][k]
b_vec  in  N*DW  row k of B; slice j = B[k][j]
busy  out  1  high in every state except IDLE
out_valid  out  1  result row valid
out_ready  in  1  downstream accepts row
out_row  out  N*AW  slice j = C[out_idx][j]
out_idx  out  clog2(N)  row index of out_row (minimum width 1)
done  out  1  one-cycle pulse after the last row handshake

Behaviour:
- Reset (async, any state): FSM to IDLE; all accumulators, skew registers, PE pipeline registers and valid bits cleared.
- Reset values of outputs: in_ready=0, busy=0, out_valid=0, out_row=0, out_idx=0, done=0.
- FSM states: IDLE, LOAD, DRAIN, READ.
- IDLE -> LOAD on start with k_len>0: clear all accumulators, load the beat counter with k_len.
- IDLE -> DRAIN on start with k_len=0: accumulators cleared; all results are 0.
- LOAD: in_ready=1. A beat is accepted on each edge with in_valid&in_ready. Gaps in in_valid are legal and become bubbles, because a valid bit travels with each operand. LOAD -> DRAIN on the edge accepting beat K.
- Skew and MAC timing: row i of A is delayed i cycles; column j of B is delayed j cycles. A beat accepted at edge e contributes A[i][k]*B[k][j] to PE(i,j) at edge e+1+i+j.
- PE datapath: a passes east, b passes south, one register per hop.
- DRAIN: lasts exactly 2N-1 cycles, counted by a drain counter, then -> READ. No operands are accepted.
- READ: rows presented in order idx=0..N-1. out_valid=1, and out_row/out_idx hold stable while out_ready=0. On an edge with out_valid&out_ready, advance the index.
- After the handshake on row N-1: -> IDLE, done=1 for exactly one cycle (coincident with the first IDLE cycle), out_valid=0.
- Arithmetic: signed two's complement DW x DW product, sign-extended to AW. Accumulation wraps modulo 2^AW. The default AW cannot overflow for K <= 2^KW-1.
- start in any state other than IDLE: ignored. k_len is sampled only with an accepted start.
- in_valid outside LOAD: ignored; no side effects.
- out_ready while out_valid=0: ignored.
- A new job may start in the cycle done is high, since the FSM is already in IDLE.
- Reset mid-job: job aborted, no done pulse, no partial rows emitted.

Test Plan:
1. N=4, DW=16, K=4, A=identity, B[k][j]=4k+j+1 (values 1..16), out_ready=1 -> rows equal B exactly; done exactly 1 cycle; busy high from the edge after start until done.
2. K=3, A all -2, B all 3 -> every C element = -18, sign-extended correctly in the AW=40 slices.
3. K=4 with in_valid deasserted every other cycle -> results identical to scenario 1; DRAIN begins on the edge accepting beat 4.
4. out_ready held low for 5 cycles on row 1 -> out_row/out_idx stable throughout; rows emitted in order 0,1,2,3; done after the row 3 handshake.
5. start with k_len=0 -> no beats accepted, 4 rows of zeros; then start asserted while busy -> ignored, and the counters are unaffected.
6. rst asserted mid-LOAD after 2 of 4 beats -> outputs return to their reset values at once. A fresh K=4 job then matches scenario 1 with no residue from the aborted job.

Source files
------------

// File: rtl/systolic_mm_engine.sv
`default_nettype none
// ============================================================================
// Module      : systolic_mm_engine
// Description : N x N output-stationary systolic engine computing C = A x B
//               with a per-job inner dimension and row-serial result readout.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_mm_engine #(
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int KW = 8,
    parameter int AW = 2*DW+KW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [KW-1:0]              k_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*DW-1:0]            a_vec,
    input  logic [N*DW-1:0]            b_vec,
    output logic                       busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N*AW-1:0]            out_row,
    output logic [((N>1)?$clog2(N):1)-1:0] out_idx,
    output logic                       done
);

    localparam int c_IW  = (N > 1) ? $clog2(N) : 1;
    localparam int c_DCW = $clog2(2*N);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_READ  = 2'd3;

    localparam logic [c_DCW-1:0] c_DRAIN_LAST = c_DCW'(2*N-2);
    localparam logic [c_IW-1:0]  c_LAST_IDX   = c_IW'(N-1);

    logic [1:0]       r_state;
    logic [KW-1:0]    r_beats;
    logic [c_DCW-1:0] r_drain;
    logic [c_IW-1:0]  r_idx;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_out_valid;
    logic             r_done;

    logic w_accept;
    logic w_clear;

    logic signed [DW-1:0] w_a_sk [N];
    logic signed [DW-1:0] w_b_sk [N];
    logic                 w_v_sk [N];

    logic signed [DW-1:0] w_a_in [N][N];
    logic signed [DW-1:0] w_b_in [N][N];
    logic                 w_v_in [N][N];
    logic signed [AW-1:0] w_acc  [N][N];

    // r_in_ready is high exactly while in LOAD
    assign w_accept = r_in_ready & in_valid;
    assign w_clear  = (r_state == c_IDLE) & start;

    // ------------------------------------------------------------------------
    // Job control
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_beats     <= '0;
            r_drain     <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (k_len != '0) begin
                            r_state    <= c_LOAD;
                            r_beats    <= k_len;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state <= c_DRAIN;
                            r_drain <= c_DRAIN_LAST;
                        end
                    end
                end
                c_LOAD: begin
                    if (in_valid) begin
                        r_beats <= r_beats - KW'(1);
                        if (r_beats == KW'(1)) begin
                            r_state    <= c_DRAIN;
                            r_in_ready <= 1'b0;
                            r_drain    <= c_DRAIN_LAST;
                        end
                    end
                end
                c_DRAIN: begin
                    // Last skewed beat reaches PE(N-1,N-1) on the exit edge
                    if (r_drain == '0) begin
                        r_state     <= c_READ;
                        r_out_valid <= 1'b1;
                        r_idx       <= '0;
                    end else begin
                        r_drain <= r_drain - c_DCW'(1);
                    end
                end
                c_READ: begin
                    if (out_ready) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_state     <= c_IDLE;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_idx       <= '0;
                        end else begin
                            r_idx <= r_idx + c_IW'(1);
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Input skew: row i of A and column i of B are delayed i cycles
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_skew
        logic signed [DW-1:0] r_a_d [0:i];
        logic signed [DW-1:0] r_b_d [0:i];
        logic                 r_v_d [0:i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s <= i; s++) begin
                    r_a_d[s] <= '0;
                    r_b_d[s] <= '0;
                    r_v_d[s] <= 1'b0;
                end
            end else begin
                r_a_d[0] <= $signed(a_vec[i*DW +: DW]);
                r_b_d[0] <= $signed(b_vec[i*DW +: DW]);
                r_v_d[0] <= w_accept;
                for (int s = 1; s <= i; s++) begin
                    r_a_d[s] <= r_a_d[s-1];
                    r_b_d[s] <= r_b_d[s-1];
                    r_v_d[s] <= r_v_d[s-1];
                end
            end
        end

        assign w_a_sk[i] = r_a_d[i];
        assign w_b_sk[i] = r_b_d[i];
        assign w_v_sk[i] = r_v_d[i];
    end

    // ------------------------------------------------------------------------
    // PE grid: a and its valid travel east, b travels south
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_pe_row
        for (genvar j = 0; j < N; j++) begin : g_pe_col
            logic signed [2*DW-1:0] w_prod;
            logic signed [AW-1:0]   r_acc;

            if (j == 0) begin : g_a_edge
                assign w_a_in[i][j] = w_a_sk[i];
                assign w_v_in[i][j] = w_v_sk[i];
            end else begin : g_a_hop
                logic signed [DW-1:0] r_a;
                logic                 r_v;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_a <= '0;
                        r_v <= 1'b0;
                    end else begin
                        r_a <= w_a_in[i][j-1];
                        r_v <= w_v_in[i][j-1];
                    end
                end
                assign w_a_in[i][j] = r_a;
                assign w_v_in[i][j] = r_v;
            end

            if (i == 0) begin : g_b_edge
                assign w_b_in[i][j] = w_b_sk[j];
            end else begin : g_b_hop
                logic signed [DW-1:0] r_b;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) r_b <= '0;
                    else     r_b <= w_b_in[i-1][j];
                end
                assign w_b_in[i][j] = r_b;
            end

            assign w_prod = w_a_in[i][j] * w_b_in[i][j];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (w_clear) begin
                    r_acc <= '0;
                end else if (w_v_in[i][j]) begin
                    r_acc <= r_acc + {{(AW-2*DW){w_prod[2*DW-1]}}, w_prod};
                end
            end

            assign w_acc[i][j] = r_acc;
        end
    end

    // ------------------------------------------------------------------------
    // Row-serial readout
    // ------------------------------------------------------------------------
    for (genvar j = 0; j < N; j++) begin : g_out
        assign out_row[j*AW +: AW] = r_out_valid ? w_acc[r_idx][j] : '0;
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_idx   = r_idx;
    assign done      = r_done;

endmodule
`default_nettype wire
